serial_deserializer: RTL and testbench
======================================

# serial_deserializer

Receives a serial bit stream, one bit per qualified clock, and assembles `WIDTH`-bit words. Presents each word on a valid/ready output port through a one-word holding register. A parameter selects MSB-first or LSB-first assembly, so the block also performs bit-order reversal at the serial/parallel boundary. It sits on the receive side of the serial link, between the line interface and the word-level datapath.

## Interface
- `WIDTH`, default 4: word width in bits; must be ≥2.
- `MSB_FIRST`, default 1: 1 = first received bit lands in `data_out[WIDTH-1]`; 0 = first received bit lands in `data_out[0]`.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `ser_in` input 1: serial data bit.
- `bit_valid` input 1: `ser_in` is sampled on this edge.
- `data_out` output WIDTH: assembled word; stable while `out_valid`=1.
- `out_valid` output 1: holding register contains an unconsumed word.
- `out_ready` input 1: consumer accepts the word on an edge where `out_valid`&&`out_ready`.
- `overflow` output 1: one-cycle pulse when a completed word is dropped.
- `parity_err` output 1: parity result for the word in `data_out`; always 0 without the parity feature.
- `busy` output 1: a partial word is in the shift register (`bit_cnt`≠0).

## Operation
- Reset values:
  - `data_out`=0, `out_valid`=0, `overflow`=0, `parity_err`=0, `busy`=0.
  - Shift register=0, `bit_cnt`=0, state=IDLE.
- FSM states:
  - **IDLE**: `bit_cnt`=0. `bit_valid` → SHIFT and shift in bit 0.
  - **SHIFT**: each `bit_valid` shifts in one bit and increments `bit_cnt`. After data bit `WIDTH-1` is shifted in:
    - with parity → PARITY;
    - without parity → word complete, go to IDLE.
  - **PARITY** (compiled in only): the next `bit_valid` samples the parity bit; word complete, go to IDLE.
- Cycles with `bit_valid`=0 hold all state. Gaps between bits are unlimited.
- Shift direction:
  - `MSB_FIRST`=1: shift left, new bit enters at bit 0.
  - `MSB_FIRST`=0: shift right, new bit enters at bit `WIDTH-1`.
  - For the same stream, the `MSB_FIRST`=0 word is the bit-reverse of the `MSB_FIRST`=1 word.
- Word completion, on the completing edge:
  - if `out_valid`=0, or `out_valid`&&`out_ready` on the same edge: load `data_out`/`parity_err`; `out_valid`=1.
  - else: the new word is dropped, `data_out` keeps the old word, and `overflow`=1 for exactly one cycle.
- If `out_valid`&&`out_ready` with no completing word, `out_valid` clears. `data_out` keeps its last value.
- `bit_cnt` wraps to 0 on word completion; no partial state carries into the next word.

## Timing
- Latency: `data_out`/`out_valid` are visible on the edge that samples the last bit (data bit or parity bit), i.e. registered, one cycle after the bit is presented.
- Back-to-back words need no idle cycle: bit 0 of the next word may be sampled on the edge after completion.
- Reset asserted mid-word discards the partial word and any held word. The first `bit_valid` after deassertion is bit 0.
- `out_ready` has no combinational path to any output.

## Configuration
- `SERIAL_DESER_PARITY_EN` defined:
  - one even-parity bit follows every `WIDTH` data bits;
  - `parity_err` = XOR of the data bits and the parity bit, registered with the word;
  - the word is delivered regardless of the error.
- Not defined: no PARITY state, frames are `WIDTH` bits, and `parity_err` is tied 0.

## Structure
- Package `serial_deser_pkg` holds:
  - the state enum `deser_state_t` (IDLE, SHIFT, PARITY);
  - the counter width constant function, `$clog2(WIDTH+1)`.
- One sub-module, `deser_out_buf`: the one-word holding register. It contains the valid/ready, drop and overflow logic and takes a `load` strobe, word and parity flag from the FSM.

## Test plan
- Reset: assert `rst` mid-stream → all outputs 0 immediately, with no clock required.
- `MSB_FIRST`=1, `out_ready`=1, bits 1,0,1,1 on consecutive cycles → `data_out`=4'b1011, `out_valid` high exactly one cycle, on the edge sampling the 4th bit.
- `MSB_FIRST`=0, same stream with random `bit_valid` gaps → `data_out`=4'b1101 (bit-reverse of 1011).
- `out_ready`=0, words 1011 then 0110 back-to-back:
  - `data_out` stays 4'b1011 and `overflow` pulses once at the 8th bit;
  - then raise `out_ready` → `out_valid` clears the next cycle.
- Reset mid-word: 2 bits, pulse `rst`, then 0,1,1,0 → `data_out`=4'b0110 (MSB-first), no stale bits.
- With `SERIAL_DESER_PARITY_EN`:
  - 1,0,1,1 + parity 1 → `parity_err`=0;
  - 1,0,1,1 + parity 0 → `parity_err`=1, and `data_out`=4'b1011 still delivered.

Source files
------------

// File: rtl/serial_deser_pkg.sv
// Shared types and helpers for the serial deserializer.
package serial_deser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } deser_state_t;

  // Bit counter width. It must hold WIDTH so that the parity phase can
  // keep the counter non-zero while the word waits for its parity bit.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/deser_out_buf.sv
// One-word holding register with valid/ready handshake. A completed word is
// accepted when the register is empty or is being drained on the same edge;
// otherwise the word is dropped and a one-cycle overflow pulse is raised.
module deser_out_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_parity,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overflow,
  output logic             o_parity_err
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overflow;
  logic             r_parity_err;
  logic             w_drain;

  assign w_drain = r_valid && i_out_ready;

  // Load, drop or drain the held word; overflow is a single-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_overflow   <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      if (i_load) begin
        if (!r_valid || w_drain) begin
          r_data       <= i_word;
          r_parity_err <= i_parity;
          r_valid      <= 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (w_drain) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data       = r_data;
  assign o_valid      = r_valid;
  assign o_overflow   = r_overflow;
  assign o_parity_err = r_parity_err;

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel receiver: assembles WIDTH-bit words from a qualified
// serial stream, MSB-first or LSB-first, and hands them to a one-word
// valid/ready holding register.
// Optional feature macro: SERIAL_DESER_PARITY_EN adds one even-parity bit
// after every word and reports the check on parity_err.
module serial_deserializer
  import serial_deser_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             bit_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow,
  output logic             parity_err,
  output logic             busy
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  deser_state_t     r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_bit_cnt;

  logic [WIDTH-1:0] w_shift_next;
  logic             w_load;
  logic [WIDTH-1:0] w_word;
  logic             w_parity;

  // Bit order is fixed at elaboration: MSB-first shifts left, LSB-first
  // shifts right, so the two builds see bit-reversed words.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shift_next = {r_shift[WIDTH-2:0], ser_in};
    end else begin : g_lsb_first
      assign w_shift_next = {ser_in, r_shift[WIDTH-1:1]};
    end
  endgenerate

  // Word-complete strobe toward the holding register, same edge as the last bit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_load   = 1'b0;
    w_word   = w_shift_next;
    w_parity = 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
    if (r_state == PARITY && bit_valid) begin
      w_load   = 1'b1;
      w_word   = r_shift;
      w_parity = ^{r_shift, ser_in};
    end
`else
    if (r_state == SHIFT && bit_valid && r_bit_cnt == LAST_IDX) begin
      w_load = 1'b1;
    end
`endif
  end

  // Frame FSM: shift qualified bits and count them; idle cycles hold state.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (bit_valid) begin
      case (r_state)
        IDLE: begin
          r_shift   <= w_shift_next;
          r_bit_cnt <= CNT_W'(1);
          r_state   <= SHIFT;
        end
        SHIFT: begin
          r_shift <= w_shift_next;
          if (r_bit_cnt == LAST_IDX) begin
`ifdef SERIAL_DESER_PARITY_EN
            r_bit_cnt <= CNT_W'(WIDTH);
            r_state   <= PARITY;
`else
            r_bit_cnt <= '0;
            r_state   <= IDLE;
`endif
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        default: begin
          // Parity bit consumed (or an unreachable encoding): frame ends.
          r_bit_cnt <= '0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign busy = (r_bit_cnt != '0);

  deser_out_buf #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_word      (w_word),
    .i_parity    (w_parity),
    .i_out_ready (out_ready),
    .o_data      (data_out),
    .o_valid     (out_valid),
    .o_overflow  (overflow),
    .o_parity_err(parity_err)
  );

endmodule

// File: tb/tb_serial_deserializer.sv
// Self-checking bench: drives one stream into an MSB-first and an LSB-first
// instance; a scoreboard queue holds expected words, popped on each handshake.
module tb_serial_deserializer;

  localparam int W = 4;
`ifdef SERIAL_DESER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         ser_in = 1'b0;
  logic         bit_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] data_m, data_l;
  logic         valid_m, valid_l, ovf_m, ovf_l, perr_m, perr_l, busy_m, busy_l;

  always #5 clk = ~clk;

  serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .ser_in(ser_in), .bit_valid(bit_valid),
    .data_out(data_m), .out_valid(valid_m), .out_ready(out_ready),
    .overflow(ovf_m), .parity_err(perr_m), .busy(busy_m)
  );

  serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .ser_in(ser_in), .bit_valid(bit_valid),
    .data_out(data_l), .out_valid(valid_l), .out_ready(out_ready),
    .overflow(ovf_l), .parity_err(perr_l), .busy(busy_l)
  );

  int n_vec = 0;
  int n_err = 0;
  int ovf_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] word;
    logic         perr;
  } exp_t;

  exp_t sb[$];

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = v[W-1-i];
    return r;
  endfunction

  // Scoreboard: each negedge with valid&&ready is one word taken on the next edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && valid_m && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(valid_m), 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_word_msb", 32'(data_m), 32'(e.word));
        check("sb_word_lsb", 32'(data_l), 32'(rev(e.word)));
        check("sb_valid_lsb", 32'(valid_l), 32'd1);
        check("sb_perr_msb", 32'(perr_m), 32'(e.perr));
        check("sb_perr_lsb", 32'(perr_l), 32'(e.perr));
      end
    end
  end

  always @(negedge clk) if (ovf_m) ovf_total++;

  // One qualified bit after 'gap' idle cycles; idle cycles carry junk on ser_in.
  task automatic send_bit(input logic b, input int gap);
    repeat (gap) begin
      ser_in = 1'($urandom);
      @(posedge clk); #1;
    end
    ser_in    = b;
    bit_valid = 1'b1;
    @(posedge clk); #1;
    bit_valid = 1'b0;
    ser_in    = 1'($urandom);
  endtask

  // Whole frame, MSB of 'w' on the wire first; bad_par inverts the even-parity bit.
  task automatic send_word(input logic [W-1:0] w, input bit bad_par, input int maxgap,
                           input bit expect_it);
    exp_t e;
    if (expect_it) begin
      e.word = w;
      e.perr = PAR_EN ? bad_par : 1'b0;
      sb.push_back(e);
    end
    for (int i = W - 1; i >= 0; i--) send_bit(w[i], int'($urandom_range(maxgap, 0)));
    if (PAR_EN) send_bit((^w) ^ bad_par, int'($urandom_range(maxgap, 0)));
  endtask

  initial begin
    int ovf_base;

    // Reset: outputs clear asynchronously, before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_data_msb", 32'(data_m), 32'd0);
    check("rst_data_lsb", 32'(data_l), 32'd0);
    check("rst_valid", 32'(valid_m), 32'd0);
    check("rst_ovf", 32'(ovf_m), 32'd0);
    check("rst_perr", 32'(perr_m), 32'd0);
    check("rst_busy", 32'(busy_m | busy_l), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Consecutive bits 1,0,1,1; word visible one cycle only with ready high.
    out_ready = 1'b1;
    send_word(4'b1011, 1'b0, 0, 1'b1);
    @(negedge clk);
    check("basic_valid_hi", 32'(valid_m), 32'd1);
    check("basic_word", 32'(data_m), 32'hb);
    check("basic_busy_done", 32'(busy_m), 32'd0);
    @(negedge clk);
    check("basic_valid_one_cycle", 32'(valid_m), 32'd0);
    @(posedge clk); #1;

    // Same stream with random gaps; the LSB-first build yields the bit-reverse.
    send_word(4'b1011, 1'b0, 3, 1'b1);
    @(negedge clk);
    check("gap_lsb_word", 32'(data_l), 32'hd);
    check("gap_msb_word", 32'(data_m), 32'hb);
    @(posedge clk); #1;

    // Consumer stalled: second back-to-back word is dropped with one overflow pulse.
    out_ready = 1'b0;
    ovf_base  = ovf_total;
    send_word(4'b1011, 1'b0, 0, 1'b1);
    send_word(4'b0110, 1'b0, 0, 1'b0);
    @(negedge clk);
    check("ovf_pulse_msb", 32'(ovf_m), 32'd1);
    check("ovf_pulse_lsb", 32'(ovf_l), 32'd1);
    check("ovf_data_kept", 32'(data_m), 32'hb);
    @(negedge clk);
    check("ovf_pulse_end", 32'(ovf_m), 32'd0);
    check("ovf_count", 32'(ovf_total - ovf_base), 32'd1);
    check("ovf_valid_held", 32'(valid_m), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("drain_valid_clear", 32'(valid_m), 32'd0);
    check("drain_data_kept", 32'(data_m), 32'hb);
    @(posedge clk); #1;

    // Random words, back-to-back or gapped, consumer always ready.
    for (int k = 0; k < 8; k++)
      send_word(4'($urandom), 1'($urandom), (k % 2 == 0) ? 0 : 2, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("stream_no_ovf", 32'(ovf_total - ovf_base), 32'd1);
    @(posedge clk); #1;

    // Reset mid-word with a word held: everything is discarded.
    out_ready = 1'b0;
    send_word(4'b1001, 1'b0, 0, 1'b0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    @(negedge clk);
    check("pre_rst_busy", 32'(busy_m), 32'd1);
    check("pre_rst_valid", 32'(valid_m), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_data", 32'(data_m), 32'd0);
    check("midrst_valid", 32'(valid_m | valid_l), 32'd0);
    check("midrst_busy", 32'(busy_m | busy_l), 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send_word(4'b0110, 1'b0, 0, 1'b1);
    @(negedge clk);
    check("post_rst_word", 32'(data_m), 32'h6);
    @(posedge clk); #1;

`ifdef SERIAL_DESER_PARITY_EN
    // Good and bad parity; the word is delivered either way.
    send_word(4'b1011, 1'b0, 0, 1'b1);
    @(negedge clk);
    check("par_good_err", 32'(perr_m), 32'd0);
    @(posedge clk); #1;
    send_word(4'b1011, 1'b1, 0, 1'b1);
    @(negedge clk);
    check("par_bad_err", 32'(perr_m), 32'd1);
    check("par_bad_word", 32'(data_m), 32'hb);
    check("par_bad_valid", 32'(valid_m), 32'd1);
    @(posedge clk); #1;
`endif

    @(negedge clk);
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
